// File: rtl/l1i_cache_refill.sv
// N-way set-associative L1 instruction cache with an integrated line refill
// engine. Hits answer one cycle after acceptance; misses fetch a whole line in
// MEM_W-wide beats, install it in a victim way and answer from the line buffer.
//
// Handshake rules: a request transfers on a cycle where req_valid && req_ready.
// A memory request transfers on mem_req_valid && mem_req_ready, and
// mem_req_addr holds until then. rsp_valid and mem_rsp_valid are one-cycle
// qualifiers with no back-pressure.
module l1i_cache_refill #(
  parameter int OFFSET_BITS = 4,
  parameter int SET_BITS    = 5,
  parameter int WAYS        = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [MEM_W-1:0]  mem_rsp_data
);

  localparam int TAG_BITS = ADDR_W - SET_BITS - OFFSET_BITS;
  localparam int SETS     = 1 << SET_BITS;
  localparam int LINE_W   = (1 << OFFSET_BITS) * 8;
  localparam int BEATS    = LINE_W / MEM_W;
  localparam int WORDS    = LINE_W / DATA_W;
  localparam int WB       = $clog2(DATA_W / 8);
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WIDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESPOND, S_FLUSH
  } state_t;

  // state is kept as a plainly named register so checkers can bind to it
  state_t state, state_next;

  logic [ADDR_W-1:0]   addr_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [LINE_W-1:0]   line_buf;
  logic [SET_BITS-1:0] flush_cnt;
  logic                flush_pend;
  logic [DATA_W-1:0]   data_hold;

  logic [SETS-1:0]     valid_q [WAYS];
  logic [TAG_BITS-1:0] tag_q   [WAYS][SETS];
  logic [LINE_W-1:0]   line_q  [WAYS][SETS];
  logic [WAY_W-1:0]    rr_q    [SETS];

  logic [SET_BITS-1:0] cur_set;
  logic [TAG_BITS-1:0] cur_tag;
  logic [WIDX_W-1:0]   cur_widx;
  logic                hit;
  logic [LINE_W-1:0]   hit_line;
  logic                all_valid;
  logic [WAY_W-1:0]    victim;
  logic [WAY_W-1:0]    rr_next;
  logic [LINE_W-1:0]   fill_line;
  logic                beat_fire;
  logic                last_beat;
  logic [DATA_W-1:0]   lookup_word;
  logic [DATA_W-1:0]   buf_word;

  assign cur_set   = addr_q[OFFSET_BITS +: SET_BITS];
  assign cur_tag   = addr_q[ADDR_W-1 -: TAG_BITS];
  assign cur_widx  = WIDX_W'(addr_q[OFFSET_BITS-1:0] >> WB);
  assign beat_fire = (state == S_REFILL) && mem_rsp_valid;
  assign last_beat = beat_fire && (beat_q == BEAT_W'(BEATS - 1));
  assign rr_next   = (WAYS == 1) ? '0 : rr_q[cur_set] + WAY_W'(1);

  assign mem_req_addr = {addr_q[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign lookup_word  = hit_line[cur_widx*DATA_W +: DATA_W];
  assign buf_word     = line_buf[cur_widx*DATA_W +: DATA_W];
  assign rsp_data     = !rsp_valid ? data_hold :
                        (state == S_RESPOND) ? buf_word : lookup_word;

  // Tag compare across all ways of the latched set
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][cur_set] && (tag_q[w][cur_set] == cur_tag)) begin
        hit      = 1'b1;
        hit_line = line_q[w][cur_set];
      end
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    all_valid = 1'b1;
    victim    = rr_q[cur_set];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][cur_set]) begin
        all_valid = 1'b0;
        victim    = WAY_W'(w);
      end
    end
  end

  // Line as it will be installed: buffer with the current beat merged in
  always_comb begin
    fill_line = line_buf;
    fill_line[beat_q*MEM_W +: MEM_W] = mem_rsp_data;
  end

  // Next-state and handshake outputs. A flush pulse drops req_ready in the
  // same cycle so no request is accepted only to be discarded by the flush.
  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !flush;
        if (flush)          state_next = S_FLUSH;
        else if (req_valid) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          rsp_valid = 1'b1;
          req_ready = !flush;
          if (flush)          state_next = S_FLUSH;
          else if (req_valid) state_next = S_LOOKUP;
          else                state_next = S_IDLE;
        end else begin
          // a flush seen here is deferred so the missing fetch still returns
          state_next = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = S_REFILL;
      end
      S_REFILL: begin
        if (last_beat) state_next = S_RESPOND;
      end
      S_RESPOND: begin
        rsp_valid  = 1'b1;
        state_next = (flush_pend || flush) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (flush_cnt == '1) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control registers: state, latched address, beat/flush counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
      data_hold  <= '0;
    end else begin
      state <= state_next;
      if (req_valid && req_ready) addr_q <= req_addr;
      if (state == S_MISS_REQ)    beat_q <= '0;
      else if (beat_fire)         beat_q <= beat_q + BEAT_W'(1);
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + SET_BITS'(1) : '0;
      if (state_next == S_FLUSH)
        flush_pend <= 1'b0;
      else if (flush && ((state == S_MISS_REQ) || (state == S_REFILL) ||
                         (state == S_RESPOND) || (state == S_LOOKUP && !hit)))
        flush_pend <= 1'b1;
      if (rsp_valid) data_hold <= rsp_data;
    end
  end

  // Valid bits and replacement pointers: set on fill, swept clear by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (state == S_FLUSH) begin
      for (int w = 0; w < WAYS; w++) valid_q[w][flush_cnt] <= 1'b0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (last_beat) begin
      valid_q[victim][cur_set] <= 1'b1;
      if (all_valid) rr_q[cur_set] <= rr_next;
    end
  end

  // Tag/data arrays and line buffer carry no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (beat_fire) line_buf[beat_q*MEM_W +: MEM_W] <= mem_rsp_data;
    if (last_beat) begin
      tag_q[victim][cur_set]  <= cur_tag;
      line_q[victim][cur_set] <= fill_line;
    end
  end

endmodule

// File: tb/tb_l1i_cache_refill.sv
// Directed bench for l1i_cache_refill: cold miss, back-to-back hits, stalled
// refill, round-robin replacement, flush during refill and async reset.
module tb_l1i_cache_refill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  l1i_cache_refill dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every response cycle must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", rsp_data, 64'hx);
      else check("rsp_data", rsp_data, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic send_req(input logic [31:0] addr);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    check("req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_mreq(input logic [31:0] line_addr);
    int n = 0;
    @(negedge clk);
    while (!mem_req_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("miss_latency", n, 1);
    check("mreq_valid", mem_req_valid, 1);
    check("mreq_addr", mem_req_addr, line_addr);
  endtask

  task automatic accept_mreq(input logic [31:0] line_addr, input int delay);
    repeat (delay) begin
      @(negedge clk);
      check("mreq_hold", {mem_req_valid, mem_req_addr}, {1'b1, line_addr});
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // full miss: request, memory request, four beats, single response
  task automatic miss(input logic [31:0] addr, input logic [127:0] ln,
                      input int delay, input int gap, input int flush_at);
    logic [31:0] line_addr;
    line_addr = {addr[31:4], 4'h0};
    send_req(addr);
    wait_mreq(line_addr);
    accept_mreq(line_addr, delay);
    for (int b = 0; b < 4; b++) begin
      if (b == flush_at) pulse_flush();
      if (b == 3) exp_q.push_back(ln[addr[3:2]*32 +: 32]);
      send_beat(ln[b*32 +: 32], gap);
    end
    @(negedge clk);
    check("miss_rsp_valid", rsp_valid, 1);
    @(negedge clk);
    check("miss_rsp_single", rsp_valid, 0);
  endtask

  task automatic hit(input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    send_req(addr);
    @(negedge clk);
    check("hit_valid", rsp_valid, 1);
    check("hit_no_mem", mem_req_valid, 0);
  endtask

  task automatic count_flush();
    int n = 0;
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("flush_cycles", n, 32);
  endtask

  // directed sequence
  initial begin
    logic [127:0] l1000, l2040, l3080, l4050, l0000, l0200, l0400;
    l1000 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    l2040 = {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000};
    l3080 = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    l4050 = {32'hBEEF0003, 32'hBEEF0002, 32'hBEEF0001, 32'hBEEF0000};
    l0000 = {32'h0A000003, 32'h0A000002, 32'h0A000001, 32'h0A000000};
    l0200 = {32'h0B000003, 32'h0B000002, 32'h0B000001, 32'h0B000000};
    l0400 = {32'h0C000003, 32'h0C000002, 32'h0C000001, 32'h0C000000};

    // reset values
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_mreq_valid", mem_req_valid, 0);
    check("rst_mreq_addr", mem_req_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // cold miss, 0x1004 -> word 1 of line 0x1000
    miss(32'h0000_1004, l1000, 0, 0, -1);

    // back-to-back hits on three consecutive cycles
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h33333333);
    exp_q.push_back(32'h44444444);
    req_valid = 1'b1;
    req_addr  = 32'h1000;
    @(posedge clk); #1;
    req_addr = 32'h1008;
    @(negedge clk);
    check("b2b_v0", {rsp_valid, req_ready, mem_req_valid}, 3'b110);
    @(posedge clk); #1;
    req_addr = 32'h100C;
    @(negedge clk);
    check("b2b_v1", {rsp_valid, req_ready, mem_req_valid}, 3'b110);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_v2", {rsp_valid, mem_req_valid}, 2'b10);
    @(negedge clk);
    check("b2b_idle", rsp_valid, 0);
    check("rsp_hold", rsp_data, 32'h44444444);

    // stalled memory request and gapped beats
    miss(32'h0000_2048, l2040, 5, 2, -1);
    hit(32'h0000_204C, 32'h5A5A0003);

    // flush during refill: refill completes, then 32 cycles not ready
    miss(32'h0000_308C, l3080, 0, 1, 2);
    count_flush();
    miss(32'h0000_1004, l1000, 0, 0, -1);

    // flush from idle also takes 32 cycles and drops the line
    @(negedge clk);
    pulse_flush();
    @(negedge clk);
    count_flush();
    miss(32'h0000_2044, l2040, 0, 0, -1);

    // async reset after two beats of a refill
    send_req(32'h0000_4054);
    wait_mreq(32'h0000_4050);
    accept_mreq(32'h0000_4050, 0);
    send_beat(32'hBEEF0000, 0);
    send_beat(32'hBEEF0001, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {req_ready, rsp_valid, mem_req_valid}, 3'b100);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_mreq_addr", mem_req_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD0000;
    @(negedge clk);
    check("late_beat_ignored", {rsp_valid, mem_req_valid, req_ready}, 3'b001);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    miss(32'h0000_4054, l4050, 0, 0, -1);

    // round-robin replacement in set 0 on a clean cache
    miss(32'h0000_0000, l0000, 0, 0, -1);
    miss(32'h0000_0200, l0200, 0, 0, -1);
    miss(32'h0000_0404, l0400, 0, 0, -1);
    hit(32'h0000_0208, 32'h0B000002);
    @(negedge clk);
    miss(32'h0000_0000, l0000, 0, 0, -1);
    hit(32'h0000_040C, 32'h0C000003);
    @(negedge clk);
    miss(32'h0000_0204, l0200, 0, 0, -1);
    hit(32'h0000_0000, 32'h0A000000);
    @(negedge clk);

    // final report
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/l1i_cache_refill.md
# l1i_cache_refill

Parametrised N-way set-associative L1 instruction cache with an integrated miss/refill engine. It sits between the fetch stage and the instruction-side memory port. Hits are served with one-cycle latency at one per cycle; misses fetch a full line in MEM_W-wide beats, fill a victim way, then return the requested word. Supports whole-cache invalidation via `flush`.

## Interface
- `OFFSET_BITS`, 4, log2 line size in bytes (line = 16 B)
- `SET_BITS`, 5, log2 number of sets (32)
- `WAYS`, 2, associativity; power of two, 1..8
- `ADDR_W`, 32, address width; `TAG_BITS = ADDR_W - SET_BITS - OFFSET_BITS` (derived)
- `DATA_W`, 32, fetch word width; power of two, ≤ line bits
- `MEM_W`, 32, refill beat width; `BEATS = 2**OFFSET_BITS*8 / MEM_W`, ≥1

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  fetch request
- `req_ready`  out  1  cache can accept request
- `req_addr`  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
- `rsp_valid`  out  1  `rsp_data` valid this cycle (no back-pressure)
- `rsp_data`  out  DATA_W  fetched word
- `flush`  in  1  single-cycle pulse: invalidate all lines
- `mem_req_valid`  out  1  line-fill request
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  ADDR_W  line-aligned fill address (offset bits zero)
- `mem_rsp_valid`  in  1  refill beat valid
- `mem_rsp_data`  in  MEM_W  refill beat, beat 0 = lowest address

## Operation
- Address split: offset `[OFFSET_BITS-1:0]`, set `[OFFSET_BITS+SET_BITS-1:OFFSET_BITS]`, tag = remaining upper bits.
- Storage per way/set: valid bit (flops, async-cleared), tag, line. Tag/data arrays not reset.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND, FLUSH.
- IDLE: `req_ready`=1. Handshake (`req_valid && req_ready`) latches address → LOOKUP.
- LOOKUP: compare tag against all ways of the set. Hit (valid && tag equal): `rsp_valid`=1, `rsp_data` = word selected by offset from hit way; `req_ready`=1 so a new request may be accepted same cycle (stay LOOKUP) else → IDLE. Miss: `req_ready`=0 → MISS_REQ.
- MISS_REQ: `mem_req_valid`=1, `mem_req_addr` = latched addr with offset zeroed, held stable until `mem_req_ready`; then → REFILL, beat counter = 0.
- REFILL: each `mem_rsp_valid` writes beat into line buffer at counter, counter++. On beat BEATS-1: write tag, line, valid=1 into victim way → RESPOND. Beats without `mem_rsp_valid` wait indefinitely.
- RESPOND: `rsp_valid`=1 with requested word from the line buffer; → IDLE (or FLUSH if pending).
- Victim: lowest-index invalid way in the set; if all valid, per-set round-robin pointer (log2 WAYS bits), advanced mod WAYS only on fills into a fully-valid set. WAYS=1: way 0 always.
- Flush: in IDLE/LOOKUP → FLUSH next cycle (a LOOKUP hit in the flush cycle still responds). During MISS_REQ/REFILL/RESPOND: recorded pending, taken after RESPOND. FLUSH clears valid bits of one set per cycle for 2**SET_BITS cycles, resets round-robin pointers, `req_ready`=0, then → IDLE. `flush` during FLUSH is ignored.
- Multiple-way hit cannot occur by construction; not handled.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `mem_req_valid`=0, `mem_req_addr`=0; state IDLE; all valid bits 0; RR pointers 0; flush-pending 0.
- Reset mid-refill: abort immediately, no partial line marked valid; late `mem_rsp_valid` beats after reset are ignored in IDLE.
- Hit latency: accept in cycle N → `rsp_valid` in N+1. Sustained throughput 1 hit/cycle.
- Miss latency: accept N, LOOKUP N+1, `mem_req_valid` from N+2; response 1 cycle after last beat.
- `rsp_data` holds last value when `rsp_valid`=0.
- Flush duration: exactly 2**SET_BITS cycles of `req_ready`=0.

## Test plan
- Cold miss: reset, request 0x0000_1004, memory returns 0x11111111,0x22222222,0x33333333,0x44444444 → `mem_req_addr`=0x0000_1000, `rsp_data`=0x22222222 one cycle after 4th beat.
- Back-to-back hits: then requests 0x1000,0x1008,0x100C on consecutive cycles → `rsp_valid` three consecutive cycles with 0x11111111,0x33333333,0x44444444, no `mem_req_valid`.
- Replacement (WAYS=2): fill tags mapping to set 0 at 0x0000,0x0200,0x0400 → third fill evicts way 0; re-request 0x0000 misses, 0x0400 hits.
- Stalls: `mem_req_ready` low 5 cycles, then 2-cycle gaps between beats → address stable, correct line filled, single response.
- Flush: flush pulse in mid-REFILL → refill completes and responds, then `req_ready`=0 for 32 cycles; subsequent 0x1004 misses.
- Async reset mid-REFILL after 2 beats → outputs at reset values immediately; re-request same address issues fresh `mem_req_valid`.
